// File: rtl/fact_scheduler.sv
// rtl/fact_scheduler.sv - round-robin scheduler sharing one factorial engine between two requesters
module fact_scheduler #(
  parameter int N_W     = 4,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [N_W-1:0]   n0,
  input  logic [N_W-1:0]   n1,
  output logic             ack0,
  output logic             ack1,
  output logic [RES_W-1:0] result0,
  output logic [RES_W-1:0] result1,
  output logic             err0,
  output logic             err1,
  output logic             eng_go,
  output logic [N_W-1:0]   eng_n,
  input  logic             eng_err,
  input  logic             eng_done,
  input  logic [RES_W-1:0] eng_result,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  // Last timer value that still counts as a legal WAIT cycle
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [7:0]       timer_q, timer_d;
  logic             abort_q, abort_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;
  logic [RES_W-1:0] result0_q, result0_d;
  logic [RES_W-1:0] result1_q, result1_d;
  logic [N_W-1:0]   eng_n_q, eng_n_d;

  // Completion bookkeeping shared by the error, done and timeout paths
  logic             fin;
  logic [RES_W-1:0] fin_res;

  // Next-state, grant, timer and completion logic
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    timer_d   = timer_q;
    abort_d   = abort_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = err0_q;
    err1_d    = err1_q;
    result0_d = result0_q;
    result1_d = result1_q;
    eng_n_d   = eng_n_q;
    fin       = 1'b0;
    fin_res   = '0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not served last wins
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          eng_n_d = gnt_d ? n1 : n0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        if (eng_err) begin
          abort_d = 1'b1;
          fin     = 1'b1;
          state_d = S_RESP;
        end else begin
          abort_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        // eng_done takes priority over a coincident timeout
        if (eng_done) begin
          abort_d = 1'b0;
          fin     = 1'b1;
          fin_res = eng_result;
          state_d = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          abort_d = 1'b1;
          fin     = 1'b1;
          state_d = S_RESP;
        end
      end
      default: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
    endcase

    if (fin) begin
      if (gnt_q) begin
        ack1_d    = 1'b1;
        err1_d    = abort_d;
        result1_d = fin_res;
      end else begin
        ack0_d    = 1'b1;
        err0_d    = abort_d;
        result0_d = fin_res;
      end
    end
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      timer_q   <= '0;
      abort_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      result0_q <= '0;
      result1_q <= '0;
      eng_n_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      abort_q   <= abort_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      result0_q <= result0_d;
      result1_q <= result1_d;
      eng_n_q   <= eng_n_d;
    end
  end

  // eng_go must be suppressed in the same ISSUE cycle that eng_err reports a bad operand
  assign eng_go  = (state_q == S_ISSUE) && !eng_err;
  assign busy    = (state_q != S_IDLE);
  assign state   = state_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign result0 = result0_q;
  assign result1 = result1_q;
  assign eng_n   = eng_n_q;

endmodule

// File: tb/tb_fact_scheduler.sv
// tb/tb_fact_scheduler.sv - directed bench for fact_scheduler with a latency-programmable engine model
module tb_fact_scheduler;

  localparam int N_W     = 4;
  localparam int RES_W   = 32;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [N_W-1:0]   n0, n1;
  logic             ack0, ack1, err0, err1, eng_go, eng_err, eng_done, busy;
  logic [RES_W-1:0] result0, result1, eng_result;
  logic [N_W-1:0]   eng_n;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;
  int eng_lat;
  logic [7:0] eng_cnt;

  int   cyc, waits, gos;
  int   seen;

  fact_scheduler #(.N_W(N_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .n0(n0), .n1(n1),
    .ack0(ack0), .ack1(ack1), .result0(result0), .result1(result1),
    .err0(err0), .err1(err1), .eng_go(eng_go), .eng_n(eng_n),
    .eng_err(eng_err), .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  // Engine stand-in: done pulses eng_lat cycles after eng_go; eng_lat==0 means it never finishes
  always @(posedge clk) begin
    if (!rst_n) eng_cnt <= 8'd0;
    else if (eng_go && eng_lat != 0) eng_cnt <= 8'(eng_lat);
    else if (eng_cnt != 8'd0) eng_cnt <= eng_cnt - 8'd1;
  end
  assign eng_done   = (eng_cnt == 8'd1);
  assign eng_result = eng_done ? fact(eng_n) : 32'd0;
  assign eng_err    = (eng_n > 4'd12);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance negedge by negedge until an ack appears or the bound runs out
  task automatic wait_ack(input int bound, output int n_cyc, output int n_wait, output int n_go);
    n_cyc = 0; n_wait = 0; n_go = 0;
    while (n_cyc < bound) begin
      @(negedge clk);
      n_cyc++;
      if (state == 2'b10) n_wait++;
      if (eng_go) n_go++;
      if (ack0 || ack1) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; n0 = '0; n1 = '0; eng_lat = 0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", 32'({eng_go, ack0, ack1, err0, err1}), 0);
    chk("rst_res", result0 | result1, 0);
    chk("rst_eng_n", 32'(eng_n), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single request, 7-cycle engine, operand change while busy ignored
    n0 = 4'd5; req0 = 1'b1; eng_lat = 7;
    @(negedge clk);
    chk("t1_issue_state", 32'(state), 1);
    chk("t1_go", 32'(eng_go), 1);
    chk("t1_eng_n", 32'(eng_n), 5);
    n0 = 4'd9;
    wait_ack(40, cyc, waits, gos);
    chk("t1_latency", 32'(cyc + 1), 9);
    chk("t1_go_once", 32'(gos), 0);
    chk("t1_ack0", 32'(ack0), 1);
    chk("t1_ack1", 32'(ack1), 0);
    chk("t1_result0", result0, 120);
    chk("t1_err0", 32'(err0), 0);
    chk("t1_eng_n_hold", 32'(eng_n), 5);
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack0), 0);
    chk("t1_idle", 32'(state), 0);

    // Tie after reset: requester 0 first, then 1, then 0 again on the next tie
    @(negedge clk); rst_n = 1'b0; #1;
    chk("t2_rst_res0", result0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n0 = 4'd3; n1 = 4'd4; req0 = 1'b1; req1 = 1'b1; eng_lat = 3;
    wait_ack(40, cyc, waits, gos);
    chk("t2_first_ack0", 32'({ack0, ack1}), 2);
    chk("t2_first_lat", 32'(cyc), 5);
    chk("t2_result0", result0, 6);
    req0 = 1'b0;
    wait_ack(40, cyc, waits, gos);
    chk("t2_second_ack1", 32'({ack0, ack1}), 1);
    chk("t2_second_lat", 32'(cyc), 6);
    chk("t2_result1", result1, 24);
    req1 = 1'b0;
    @(negedge clk);
    n0 = 4'd2; n1 = 4'd3; req0 = 1'b1; req1 = 1'b1; eng_lat = 2;
    wait_ack(40, cyc, waits, gos);
    chk("t2_tie_ack0", 32'({ack0, ack1}), 2);
    chk("t2_tie_result0", result0, 2);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Operand out of range: no eng_go, ack two cycles later with error
    n1 = 4'd13; req1 = 1'b1; eng_lat = 7;
    wait_ack(10, cyc, waits, gos);
    chk("t3_latency", 32'(cyc), 2);
    chk("t3_no_go", 32'(gos), 0);
    chk("t3_ack", 32'({ack0, ack1}), 1);
    chk("t3_err1", 32'(err1), 1);
    chk("t3_result1", result1, 0);
    req1 = 1'b0;
    @(negedge clk);

    // Engine never answers: 64 WAIT cycles then error completion
    n0 = 4'd5; req0 = 1'b1; eng_lat = 0;
    wait_ack(100, cyc, waits, gos);
    chk("t4_latency", 32'(cyc), 66);
    chk("t4_waits", 32'(waits), 64);
    chk("t4_ack0", 32'(ack0), 1);
    chk("t4_err0", 32'(err0), 1);
    chk("t4_result0", result0, 0);
    req0 = 1'b0;
    @(negedge clk);
    chk("t4_idle", 32'(state), 0);

    // Done arrives on the timeout edge: done wins
    n0 = 4'd6; req0 = 1'b1; eng_lat = 64;
    wait_ack(100, cyc, waits, gos);
    chk("t5_latency", 32'(cyc), 66);
    chk("t5_waits", 32'(waits), 64);
    chk("t5_result0", result0, 720);
    chk("t5_err0", 32'(err0), 0);
    req0 = 1'b0;
    @(negedge clk);

    // Reset in WAIT: immediate clear, no ack, then a fresh request works
    n0 = 4'd5; req0 = 1'b1; eng_lat = 20;
    repeat (5) @(negedge clk);
    chk("t6_in_wait", 32'(state), 2);
    rst_n = 1'b0; #1;
    chk("t6_state", 32'(state), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_go", 32'(eng_go), 0);
    chk("t6_results", result0 | result1, 0);
    req0 = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1) seen++;
    end
    chk("t6_no_ack", 32'(seen), 0);
    rst_n = 1'b1;
    @(negedge clk);
    n0 = 4'd4; req0 = 1'b1; eng_lat = 3;
    wait_ack(40, cyc, waits, gos);
    chk("t6_latency", 32'(cyc), 5);
    chk("t6_ack0", 32'(ack0), 1);
    chk("t6_result0", result0, 24);
    chk("t6_err0", 32'(err0), 0);
    req0 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
